// File: rtl/hazard_pkg.sv
// Shared widths, encodings and defaults for the hazard/stall controller.
package hazard_pkg;

  // Tuse/Tnew fields are 2 bits; a Tuse of 3 means the operand is never read.
  localparam int unsigned T_W        = 2;
  localparam logic [T_W-1:0] TUSE_NEVER = 2'd3;

  // Multiply/divide type encoding on MDType_E.
  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  // Default busy lengths and the width of the MD countdown.
  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;
  localparam int unsigned MD_CNT_W     = 4;

  typedef logic [T_W-1:0] t_val_t;
  typedef logic [4:0]     reg_idx_t;

  // One source-versus-producer hazard term. Register 0 never produces a hazard.
  function automatic logic src_hazard(input reg_idx_t src, input t_val_t tuse,
                                      input reg_idx_t dst, input t_val_t tnew);
    return (src != '0) && (src == dst) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Decode-side bundle between the pipeline and the hazard/stall controller.
interface hazard_stall_ctrl_if
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  reg_idx_t   Rs_D;
  reg_idx_t   Rt_D;
  t_val_t     TuseRs_D;
  t_val_t     TuseRt_D;
  reg_idx_t   A3_E;
  reg_idx_t   A3_M;
  t_val_t     TnewE_E;
  t_val_t     TnewM_M;
  logic       MDStart_E;
  logic       MDType_E;
  logic       MDUse_D;
  logic       FlushReq_I;
  logic       PCEn_O;
  logic       FDEn_O;
  logic       Flush_FD_O;
  logic       DEClr_O;
  logic       MDBusy_O;
  logic [CNT_W-1:0] StallCnt_O;

  // Pipeline side: supplies operand/producer info, receives enables.
  modport master (
    output Rs_D, Rt_D, TuseRs_D, TuseRt_D, A3_E, A3_M, TnewE_E, TnewM_M,
           MDStart_E, MDType_E, MDUse_D, FlushReq_I,
    input  PCEn_O, FDEn_O, Flush_FD_O, DEClr_O, MDBusy_O, StallCnt_O
  );

  // Controller side.
  modport slave (
    input  Rs_D, Rt_D, TuseRs_D, TuseRt_D, A3_E, A3_M, TnewE_E, TnewM_M,
           MDStart_E, MDType_E, MDUse_D, FlushReq_I,
    output PCEn_O, FDEn_O, Flush_FD_O, DEClr_O, MDBusy_O, StallCnt_O
  );

endinterface

// File: rtl/md_busy_counter.sv
// Multiply/divide busy countdown: loads on a start, counts down to idle.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_type,
  output logic md_busy
);

  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  // State register: the remaining busy cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Next state: a start always (re)loads; otherwise count down while busy.
  always_comb begin
    cnt_d = cnt_q;
    if (md_start) begin
      cnt_d = (md_type == MD_DIV) ? MD_CNT_W'(DIV_CYC) : MD_CNT_W'(MULT_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Output: BUSY whenever the count is nonzero.
  always_comb begin
    md_busy = (cnt_q != '0);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the five-stage core: operand hazards,
// multiply/divide interlock, flush priority and a stall-cycle counter.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  bus
);

  logic             md_busy;
  logic             reg_stall;
  logic             md_stall;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_counter (
    .clk      (clk),
    .reset    (reset),
    .md_start (bus.MDStart_E),
    .md_type  (bus.MDType_E),
    .md_busy  (md_busy)
  );

  // Hazard detection: operand needed before E/M result is forwardable, or MD unit in use.
  always_comb begin
    reg_stall = src_hazard(bus.Rs_D, bus.TuseRs_D, bus.A3_E, bus.TnewE_E) |
                src_hazard(bus.Rs_D, bus.TuseRs_D, bus.A3_M, bus.TnewM_M) |
                src_hazard(bus.Rt_D, bus.TuseRt_D, bus.A3_E, bus.TnewE_E) |
                src_hazard(bus.Rt_D, bus.TuseRt_D, bus.A3_M, bus.TnewM_M);
    // A start in E counts as busy in the same cycle.
    md_stall  = bus.MDUse_D & (md_busy | bus.MDStart_E);
    stall     = reg_stall | md_stall;
  end

  // Priority mux: flush beats stall beats normal flow.
  always_comb begin
    bus.PCEn_O     = 1'b1;
    bus.FDEn_O     = 1'b1;
    bus.Flush_FD_O = 1'b0;
    bus.DEClr_O    = 1'b0;
    if (bus.FlushReq_I) begin
      bus.Flush_FD_O = 1'b1;
      bus.DEClr_O    = 1'b1;
    end else if (stall) begin
      bus.PCEn_O  = 1'b0;
      bus.FDEn_O  = 1'b0;
      bus.DEClr_O = 1'b1;
    end
  end

  // Perf counter next value: count real stall cycles, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !bus.FlushReq_I && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Perf counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Status outputs.
  always_comb begin
    bus.MDBusy_O   = md_busy;
    bus.StallCnt_O = stall_cnt_q;
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed, table-driven bench for hazard_stall_ctrl (CNT_W=4 to reach saturation).
module tb_hazard_stall_ctrl;
  import hazard_pkg::*;

  localparam int unsigned TB_CNT_W = 4;

  logic clk;
  logic reset;

  hazard_stall_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

  hazard_stall_ctrl #(
    .MULT_CYC (5),
    .DIV_CYC  (10),
    .CNT_W    (TB_CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [4:0] a3e;
    logic [4:0] a3m;
    logic [1:0] tnew_e;
    logic [1:0] tnew_m;
    logic       md_use;
    logic       flush;
    logic [3:0] exp; // {PCEn, FDEn, Flush_FD, DEClr}
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ctl();
    return {bus.PCEn_O, bus.FDEn_O, bus.Flush_FD_O, bus.DEClr_O};
  endfunction

  task automatic idle_inputs();
    bus.Rs_D       = '0;
    bus.Rt_D       = '0;
    bus.TuseRs_D   = TUSE_NEVER;
    bus.TuseRt_D   = TUSE_NEVER;
    bus.A3_E       = '0;
    bus.A3_M       = '0;
    bus.TnewE_E    = '0;
    bus.TnewM_M    = '0;
    bus.MDStart_E  = 1'b0;
    bus.MDType_E   = MD_MULT;
    bus.MDUse_D    = 1'b0;
    bus.FlushReq_I = 1'b0;
  endtask

  // Pulse reset away from any clock edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v);
    bus.Rs_D       = v.rs;
    bus.Rt_D       = v.rt;
    bus.TuseRs_D   = v.tuse_rs;
    bus.TuseRt_D   = v.tuse_rt;
    bus.A3_E       = v.a3e;
    bus.A3_M       = v.a3m;
    bus.TnewE_E    = v.tnew_e;
    bus.TnewM_M    = v.tnew_m;
    bus.MDUse_D    = v.md_use;
    bus.FlushReq_I = v.flush;
    bus.MDStart_E  = 1'b0;
  endtask

  logic [TB_CNT_W-1:0] exp_cnt;

  initial begin
    //                name        rs rt trs trt a3e a3m tne tnm mdu fl  exp
    vecs[0] = '{"load_use",        8, 0, 1, 3,  8,  0,  2,  0,  0,  0, 4'b0001};
    vecs[1] = '{"load_use_ready",  8, 0, 1, 3,  8,  0,  1,  0,  0,  0, 4'b1100};
    vecs[2] = '{"zero_reg",        0, 0, 0, 3,  0,  0,  2,  0,  0,  0, 4'b1100};
    vecs[3] = '{"rt_m_stage",      0, 5, 3, 0,  0,  5,  0,  1,  0,  0, 4'b0001};
    vecs[4] = '{"rt_m_equal",      0, 5, 3, 1,  0,  5,  0,  1,  0,  0, 4'b1100};
    vecs[5] = '{"tuse_never",      8, 0, 3, 3,  8,  0,  2,  0,  0,  0, 4'b1100};
    vecs[6] = '{"flush_over_stall",8, 0, 1, 3,  8,  0,  2,  0,  0,  1, 4'b1111};
    vecs[7] = '{"flush_alone",     0, 0, 3, 3,  0,  0,  0,  0,  0,  1, 4'b1111};
    vecs[8] = '{"md_use_idle",     0, 0, 3, 3,  0,  0,  0,  0,  1,  0, 4'b1100};
    vecs[9] = '{"rs_e_tnew0",      7, 0, 0, 3,  7,  0,  0,  0,  0,  0, 4'b1100};

    reset = 1'b0;
    idle_inputs();
    do_reset();

    // Reset state.
    check("reset_ctl", 16'(ctl()), 16'(4'b1100));
    check("reset_busy", 16'(bus.MDBusy_O), 16'd0);
    check("reset_cnt", 16'(bus.StallCnt_O), 16'd0);

    // Combinational vectors with perf-counter tracking.
    exp_cnt = '0;
    for (int i = 0; i < 10; i++) begin
      apply_vec(vecs[i]);
      #1;
      check({vecs[i].name, "_ctl"}, 16'(ctl()), 16'(vecs[i].exp));
      if (vecs[i].exp == 4'b0001 && exp_cnt != 4'hf) exp_cnt = exp_cnt + 1'b1;
      step();
      check({vecs[i].name, "_cnt"}, 16'(bus.StallCnt_O), 16'(exp_cnt));
    end

    // Divide: stall for the start cycle plus 10 busy cycles, release on cycle 12.
    idle_inputs();
    do_reset();
    bus.MDStart_E = 1'b1;
    bus.MDType_E  = MD_DIV;
    bus.MDUse_D   = 1'b1;
    #1;
    check("div_start_ctl", 16'(ctl()), 16'(4'b0001));
    check("div_start_busy", 16'(bus.MDBusy_O), 16'd0);
    step();
    bus.MDStart_E = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      check($sformatf("div_busy_%0d", c), 16'(bus.MDBusy_O), 16'd1);
      check($sformatf("div_stall_%0d", c), 16'(ctl()), 16'(4'b0001));
      step();
    end
    check("div_release_busy", 16'(bus.MDBusy_O), 16'd0);
    check("div_release_ctl", 16'(ctl()), 16'(4'b1100));
    check("div_stall_cnt", 16'(bus.StallCnt_O), 16'd11);

    // Start together with flush: flush outputs win, counter still loads.
    idle_inputs();
    do_reset();
    bus.MDStart_E  = 1'b1;
    bus.MDType_E   = MD_MULT;
    bus.MDUse_D    = 1'b1;
    bus.FlushReq_I = 1'b1;
    #1;
    check("start_flush_ctl", 16'(ctl()), 16'(4'b1111));
    step();
    bus.MDStart_E  = 1'b0;
    bus.FlushReq_I = 1'b0;
    bus.MDUse_D    = 1'b0;
    check("start_flush_busy", 16'(bus.MDBusy_O), 16'd1);
    check("start_flush_cnt", 16'(bus.StallCnt_O), 16'd0);
    for (int c = 0; c < 4; c++) step();
    check("mult_busy_last", 16'(bus.MDBusy_O), 16'd1);
    step();
    check("mult_done", 16'(bus.MDBusy_O), 16'd0);

    // Mid-operation reset aborts the countdown and clears the perf counter.
    idle_inputs();
    do_reset();
    bus.MDStart_E = 1'b1;
    bus.MDType_E  = MD_MULT;
    bus.MDUse_D   = 1'b1;
    step();
    bus.MDStart_E = 1'b0;
    step();
    step();
    check("pre_reset_busy", 16'(bus.MDBusy_O), 16'd1);
    check("pre_reset_cnt", 16'(bus.StallCnt_O), 16'd3);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_busy", 16'(bus.MDBusy_O), 16'd0);
    check("async_reset_cnt", 16'(bus.StallCnt_O), 16'd0);
    reset = 1'b0;
    step();
    check("post_reset_ctl", 16'(ctl()), 16'(4'b1100));
    check("post_reset_busy", 16'(bus.MDBusy_O), 16'd0);

    // Saturation: hold a load-use stall for 20 cycles.
    idle_inputs();
    do_reset();
    apply_vec(vecs[0]);
    for (int c = 0; c < 20; c++) step();
    check("sat_ctl", 16'(ctl()), 16'(4'b0001));
    check("sat_cnt", 16'(bus.StallCnt_O), 16'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
